// File: rtl/fp32_mult.sv
// Sequential IEEE-754 single-precision multiplier.
// Operands are latched on the first edge after reset release; a 24-iteration
// shift-add loop forms the 48-bit mantissa product, which is then normalised,
// rounded to nearest-even and packed. The result holds until the next reset.
module fp32_mult (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] flt_A,
    input  logic [31:0] flt_B,
    output logic [31:0] flt_out
);

    localparam logic [2:0] S_LOAD = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_NORM = 3'd2;
    localparam logic [2:0] S_PACK = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] K_NORMAL = 2'd0;
    localparam logic [1:0] K_ZERO   = 2'd1;
    localparam logic [1:0] K_INF    = 2'd2;
    localparam logic [1:0] K_NAN    = 2'd3;

    localparam int unsigned MANT_W = 24;
    localparam int unsigned PROD_W = 2 * MANT_W;
    localparam int unsigned EXP_W  = 10;

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic                sign;
    logic [1:0]          kind;
    logic [7:0]          exp_a;
    logic [7:0]          exp_b;
    logic [PROD_W-1:0]   acc;
    logic [PROD_W-1:0]   mcand;
    logic [MANT_W-1:0]   mplier;
    logic [4:0]          cnt;
    logic [EXP_W-1:0]    exp_r;
    logic [22:0]         frac_r;

    logic                a_nan, a_inf, a_zero;
    logic                b_nan, b_inf, b_zero;
    logic [1:0]          kind_c;
    logic [EXP_W-1:0]    exp_sum_c;
    logic                hi_c;
    logic [22:0]         mant_c;
    logic                guard_c;
    logic                sticky_c;
    logic                rup_c;
    logic [MANT_W-1:0]   rounded_c;
    logic [EXP_W-1:0]    exp_adj_c;
    logic [22:0]         frac_n_c;
    logic [31:0]         pack_c;

    // State register; reset returns to LOAD from any state
    always_ff @(posedge clk) begin
        if (!res) state <= S_LOAD;
        else      state <= state_nxt;
    end

    // Next-state sequencing: one LOAD, 24 MUL, then NORM, PACK, DONE
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: state_nxt = S_MUL;
            S_MUL:  if (cnt == 5'd23) state_nxt = S_NORM;
            S_NORM: state_nxt = S_PACK;
            S_PACK: state_nxt = S_DONE;
            S_DONE: state_nxt = S_DONE;
            default: state_nxt = S_LOAD;
        endcase
    end

    // Operand classification; denormals are treated as zero
    always_comb begin
        a_nan  = (flt_A[30:23] == 8'hFF) && (flt_A[22:0] != 23'd0);
        a_inf  = (flt_A[30:23] == 8'hFF) && (flt_A[22:0] == 23'd0);
        a_zero = (flt_A[30:23] == 8'h00);
        b_nan  = (flt_B[30:23] == 8'hFF) && (flt_B[22:0] != 23'd0);
        b_inf  = (flt_B[30:23] == 8'hFF) && (flt_B[22:0] == 23'd0);
        b_zero = (flt_B[30:23] == 8'h00);
        kind_c = K_NORMAL;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) kind_c = K_NAN;
        else if (a_inf || b_inf)                                       kind_c = K_INF;
        else if (a_zero || b_zero)                                     kind_c = K_ZERO;
    end

    // Normalisation and round-to-nearest-even of the finished product
    always_comb begin
        exp_sum_c = EXP_W'(exp_a) + EXP_W'(exp_b) - EXP_W'(127);
        hi_c      = acc[47];
        mant_c    = hi_c ? acc[46:24] : acc[45:23];
        guard_c   = hi_c ? acc[23] : acc[22];
        sticky_c  = hi_c ? (|acc[22:0]) : (|acc[21:0]);
        rup_c     = guard_c && (sticky_c || mant_c[0]);
        rounded_c = {1'b0, mant_c} + MANT_W'(rup_c);
        exp_adj_c = exp_sum_c + EXP_W'(hi_c) + EXP_W'(rounded_c[23]);
        frac_n_c  = rounded_c[23] ? 23'd0 : rounded_c[22:0];
    end

    // Final packing with special cases and exponent range clamping
    always_comb begin
        pack_c = {sign, exp_r[7:0], frac_r};
        case (kind)
            K_NAN:  pack_c = 32'h7FC0_0000;
            K_INF:  pack_c = {sign, 8'hFF, 23'd0};
            K_ZERO: pack_c = {sign, 31'd0};
            default: begin
                if ($signed(exp_r) > $signed(10'sd254))    pack_c = {sign, 8'hFF, 23'd0};
                else if ($signed(exp_r) < $signed(10'sd1)) pack_c = {sign, 31'd0};
            end
        endcase
    end

    // Datapath registers: latch, iterate, normalise, publish
    always_ff @(posedge clk) begin
        if (!res) begin
            flt_out <= 32'd0;
            sign    <= 1'b0;
            kind    <= K_NORMAL;
            exp_a   <= 8'd0;
            exp_b   <= 8'd0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= 5'd0;
            exp_r   <= '0;
            frac_r  <= 23'd0;
        end else begin
            case (state)
                S_LOAD: begin
                    sign   <= flt_A[31] ^ flt_B[31];
                    kind   <= kind_c;
                    exp_a  <= flt_A[30:23];
                    exp_b  <= flt_B[30:23];
                    mcand  <= {24'd0, 1'b1, flt_A[22:0]};
                    mplier <= {1'b1, flt_B[22:0]};
                    acc    <= '0;
                    cnt    <= 5'd0;
                end
                S_MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                end
                S_NORM: begin
                    exp_r  <= exp_adj_c;
                    frac_r <= frac_n_c;
                end
                S_PACK: flt_out <= pack_c;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_mult.sv
// Scoreboard bench for fp32_mult: stimulus queues expected flt_out values
// tagged with the cycle they are due; a monitor compares on falling edges.
module tb_fp32_mult;

    logic        clk;
    logic        res;
    logic [31:0] flt_a;
    logic [31:0] flt_b;
    logic [31:0] flt_out;

    int cyc;
    int checks;
    int passed;
    int op_id;

    typedef struct {
        int          due;
        int          op;
        int          step;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    fp32_mult dut (
        .clk     (clk),
        .res     (res),
        .flt_A   (flt_a),
        .flt_B   (flt_b),
        .flt_out (flt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int due, input int step, input logic [31:0] val);
        exp_t e;
        e.due  = due;
        e.op   = op_id;
        e.step = step;
        e.val  = val;
        sb.push_back(e);
    endtask

    // Monitor: compare every entry whose due cycle has arrived
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (e.due < cyc)
                    $display("FAIL op%0d_s%0d: check missed (due %0d, now %0d)", e.op, e.step, e.due, cyc);
                else if (flt_out !== e.val)
                    $display("FAIL op%0d_s%0d: flt_out=%08h expected %08h", e.op, e.step, flt_out, e.val);
                else
                    passed++;
            end
        end
    end

    // Reset for two edges with new operands, release, and expect the result
    // at edge 27 (zero at edge 26); operands are scrambled after LOAD.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
        int rel;
        op_id++;
        @(negedge clk);
        res   = 1'b0;
        flt_a = a;
        flt_b = b;
        push(cyc + 1, 0, 32'd0);
        push(cyc + 2, 1, 32'd0);
        repeat (2) @(negedge clk);
        res = 1'b1;
        rel = cyc;
        push(rel + 26, 2, 32'd0);
        push(rel + 27, 3, r);
        push(rel + 32, 4, r);
        @(negedge clk);
        flt_a = ~a;
        flt_b = ~b;
        while (cyc < rel + 33) @(negedge clk);
    endtask

    initial begin
        int rel;
        checks = 0;
        passed = 0;
        op_id  = 0;
        res    = 1'b0;
        flt_a  = 32'd0;
        flt_b  = 32'd0;

        run_op(32'h4391_8000, 32'h428C_A000, 32'h469F_D9E0);
        run_op(32'h4391_8000, 32'hC391_0000, 32'hC7A4_D300);
        run_op(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
        run_op(32'h3F80_0000, 32'h3F80_0001, 32'h3F80_0001);
        run_op(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000);
        run_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
        run_op(32'h8000_0000, 32'h4040_0000, 32'h8000_0000);
        run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
        run_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
        run_op(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000);

        // Abort an operation at edge 10, then run a fresh one
        op_id++;
        @(negedge clk);
        res   = 1'b0;
        flt_a = 32'h4391_8000;
        flt_b = 32'h428C_A000;
        @(negedge clk);
        res = 1'b1;
        rel = cyc;
        repeat (9) @(negedge clk);
        res = 1'b0;
        push(rel + 10, 0, 32'd0);
        run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d checks still pending, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
